instr_encode_loader: RTL and testbench
======================================

// Module: instr_encode_loader
// PURPOSE
//  Writer-side counterpart of the instruction decoder. Takes instruction field requests
//  over a valid/ready handshake and assembles 32-bit RV32 words for R-type (0110011),
//  I-type load (0000011) and S-type (0100011). Writes each word into consecutive
//  instruction-memory addresses, so a bench or boot loader can build a program for the
//  single-cycle core.
// PARAMETERS
//  ADDR_W     6   instruction memory address width (depth 2**ADDR_W words)
//  BASE_ADDR  0   first word address written after reset/clear
// PORTS
//  clk_i        in   1       clock, all state on rising edge
//  rst_i        in   1       asynchronous reset, active-high
//  req_valid_i  in   1       field request valid
//  req_ready_o  out  1       block can accept a request
//  type_i       in   2       00 R, 01 I(load), 10 S, 11 reserved
//  rd_i         in   5       destination register (R, I)
//  rs1_i        in   5       source register 1
//  rs2_i        in   5       source register 2 (R, S)
//  funct3_i     in   3       funct3 field
//  funct7_i     in   7       funct7 field (R only)
//  imm_i        in   32      signed immediate (I, S)
//  clear_i      in   1       synchronous restart: pointer back to BASE_ADDR
//  mem_we_o     out  1       instruction memory write enable, 1-cycle pulse
//  mem_addr_o   out  ADDR_W  write address = BASE_ADDR + count
//  mem_wdata_o  out  32      encoded instruction word
//  count_o      out  ADDR_W+1 words written since reset/clear
//  full_o       out  1       count_o == 2**ADDR_W
//  err_o        out  1       1-cycle pulse: request discarded
// BEHAVIOUR
//  - Reset (async, rst_i=1): state IDLE, count_o=0, mem_we_o=0, mem_addr_o=BASE_ADDR,
//    mem_wdata_o=0, err_o=0, full_o=0. req_ready_o=1 (IDLE, not full).
//  - FSM IDLE -> ENCODE -> WRITE -> IDLE. FULL is entered from WRITE when count reaches depth.
//  - IDLE: req_ready_o=1. A transfer occurs when valid & ready. Fields latch that edge -> ENCODE.
//  - ENCODE (ready=0): assemble into a word register.
//      R: {f7,rs2,rs1,f3,rd,0110011}
//      I: {imm[11:0],rs1,f3,rd,0000011}
//      S: {imm[11:5],rs2,rs1,f3,imm[4:0],0100011}
//    Reserved type: err_o pulses 1 cycle, no write, state -> IDLE.
//  - WRITE (ready=0): mem_we_o=1 for exactly one cycle, with mem_addr_o and mem_wdata_o
//    stable. count increments at the end of the cycle.
//    Next state is FULL if the new count = 2**ADDR_W, else IDLE.
//  - Latency: transfer at edge N -> mem_we_o high during cycle N+2. Throughput 1 word/3 cycles.
//  - FULL: req_ready_o=0, full_o=1, no wrap-around. Requests are held off until clear_i.
//  - clear_i has priority in every state: count=0, abort any pending word (no write), state -> IDLE.
//  - mem_wdata_o holds the last word between writes.
//  - Async reset during ENCODE/WRITE: the word is dropped and no mem_we_o pulse follows.
// CONFIGURATION
//  ENC_CHECK_EN defined:
//    - I/S imm_i outside [-2048,2047] -> err_o pulse in ENCODE; request discarded, no write.
//  ENC_CHECK_EN undefined:
//    - no range check; imm_i[11:0] is used silently.
//    - err_o only for reserved type.
// TESTING
//  1. Reset, R rd=3 rs1=1 rs2=2 f3=0 f7=0 -> we at N+2, addr 0, wdata 0x002081B3, count 1
//  2. I rd=5 rs1=2 f3=2 imm=8 -> addr 1, wdata 0x00812283
//  3. S rs2=6 rs1=2 f3=2 imm=-4 -> addr 2, wdata 0xFE612E23
//  4. ADDR_W=2: 4 requests -> full_o=1, ready=0, 5th held. clear_i -> count 0, ready=1,
//     next word at addr 0
//  5. type=11 -> err_o 1 cycle, no we, count unchanged. imm=2048 I-type:
//     with ENC_CHECK_EN -> err, no write; without -> written, imm field 0x800
//  6. rst_i pulsed during ENCODE -> no we ever follows, count_o=0, ready=1

Source files
------------

// File: rtl/instr_encode_loader.sv
// instr_encode_loader: assembles RV32 R / I(load) / S instruction words from
// field requests and writes them to consecutive instruction-memory addresses.
//
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both 1; the fields are captured on that edge. req_ready_o
// is high only in IDLE while clear_i is low, so at most one word is in flight.
//
// Optional feature macro: ENC_CHECK_EN. When it is defined, an I/S immediate
// outside [-2048, 2047] discards the request with an err_o pulse. When it is
// undefined, imm_i[11:0] is used without any range check.
//
// state_o exposes the FSM state (0 IDLE, 1 ENCODE, 2 WRITE, 3 FULL) for debug.
module instr_encode_loader #(
  parameter int          ADDR_W    = 6,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        type_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [31:0]       imm_i,
  input  logic              clear_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              err_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    WRITE  = 2'd2,
    FULL   = 2'd3
  } state_t;

  localparam logic [1:0]  TYPE_R   = 2'b00;
  localparam logic [1:0]  TYPE_I   = 2'b01;
  localparam logic [1:0]  TYPE_S   = 2'b10;
  localparam logic [6:0]  OP_R     = 7'b0110011;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] BASE  = BASE_ADDR[ADDR_W-1:0];

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q;
  logic [1:0]        type_q;
  logic [4:0]        rd_q, rs1_q, rs2_q;
  logic [2:0]        f3_q;
  logic [6:0]        f7_q;
  logic [11:0]       imm_q;
  logic              imm_ok_q;
  logic [31:0]       word_q;
  logic [31:0]       enc_word;
  logic              bad_req;
  logic              take;
  logic              load_word;
  logic              cnt_inc;

  // Only the low 12 immediate bits feed the encoding; the upper bits matter
  // solely to the optional range check.
`ifndef ENC_CHECK_EN
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm_i[31:12];
`endif

  assign take = req_valid_i & req_ready_o;

  // Encode the captured fields; reserved type or out-of-range immediate is bad.
  always_comb begin
    enc_word = 32'h0;
    bad_req  = 1'b0;
    case (type_q)
      TYPE_R: enc_word = {f7_q, rs2_q, rs1_q, f3_q, rd_q, OP_R};
      TYPE_I: begin
        enc_word = {imm_q, rs1_q, f3_q, rd_q, OP_LOAD};
        bad_req  = ~imm_ok_q;
      end
      TYPE_S: begin
        enc_word = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], OP_STORE};
        bad_req  = ~imm_ok_q;
      end
      default: bad_req = 1'b1;
    endcase
  end

  // Next-state and output decode; clear_i overrides everything.
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    mem_we_o    = 1'b0;
    err_o       = 1'b0;
    load_word   = 1'b0;
    cnt_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = ~clear_i;
        if (req_valid_i && !clear_i) state_d = ENCODE;
      end
      ENCODE: begin
        if (bad_req) begin
          err_o   = 1'b1;
          state_d = IDLE;
        end else begin
          load_word = 1'b1;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        mem_we_o = 1'b1;
        cnt_inc  = 1'b1;
        state_d  = ((count_q + 1'b1) == DEPTH) ? FULL : IDLE;
      end
      FULL: state_d = FULL;
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d   = IDLE;
      mem_we_o  = 1'b0;
      err_o     = 1'b0;
      load_word = 1'b0;
      cnt_inc   = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Words-written counter: cleared by clear_i, bumped at the end of WRITE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        count_q <= '0;
    else if (clear_i) count_q <= '0;
    else if (cnt_inc) count_q <= count_q + 1'b1;
  end

  // Capture request fields on the transfer edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      type_q   <= 2'b00;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      f3_q     <= '0;
      f7_q     <= '0;
      imm_q    <= '0;
      imm_ok_q <= 1'b1;
    end else if (take) begin
      type_q   <= type_i;
      rd_q     <= rd_i;
      rs1_q    <= rs1_i;
      rs2_q    <= rs2_i;
      f3_q     <= funct3_i;
      f7_q     <= funct7_i;
      imm_q    <= imm_i[11:0];
`ifdef ENC_CHECK_EN
      imm_ok_q <= (imm_i[31:11] == '0) || (imm_i[31:11] == '1);
`else
      imm_ok_q <= 1'b1;
`endif
    end
  end

  // Word register: only loaded by a good encode, so it holds the last word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          word_q <= 32'h0;
    else if (load_word) word_q <= enc_word;
  end

  assign mem_wdata_o = word_q;
  assign mem_addr_o  = BASE + count_q[ADDR_W-1:0];
  assign count_o     = count_q;
  assign full_o      = (count_q == DEPTH);
  assign state_o     = state_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Bench for instr_encode_loader: directed cases plus randomized requests,
// checked by a scoreboard queue against a field-arithmetic reference model.
module tb_instr_encode_loader;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;
  localparam int W      = ADDR_W + 33;

  logic              clk, rst_i, req_valid_i, req_ready_o, clear_i;
  logic [1:0]        type_i;
  logic [4:0]        rd_i, rs1_i, rs2_i;
  logic [2:0]        funct3_i;
  logic [6:0]        funct7_i;
  logic [31:0]       imm_i;
  logic              mem_we_o, full_o, err_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [ADDR_W:0]   count_o;
  logic [1:0]        state_o;

  logic [W-1:0] exp_q[$];
  int           exp_t_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           model_count = 0;

  instr_encode_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .type_i(type_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .funct3_i(funct3_i),
    .funct7_i(funct7_i), .imm_i(imm_i), .clear_i(clear_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .count_o(count_o),
    .full_o(full_o), .err_o(err_o), .state_o(state_o)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: place each field at its bit position arithmetically.
  function automatic logic [31:0] ref_word(input int t, input int rd, input int rs1,
                                           input int rs2, input int f3, input int f7,
                                           input int imm);
    int w;
    case (t)
      0: w = f7 * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12)
             + rd * (1 << 7) + 'h33;
      1: w = (imm & 'hFFF) * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12)
             + rd * (1 << 7) + 'h03;
      default: w = ((imm >>> 5) & 'h7F) * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15)
                   + f3 * (1 << 12) + (imm & 'h1F) * (1 << 7) + 'h23;
    endcase
    return w;
  endfunction

  function automatic bit ref_bad(input int t, input int imm);
    if (t == 3) return 1'b1;
`ifdef ENC_CHECK_EN
    if (t != 0 && (imm < -2048 || imm > 2047)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Driver: wait for ready, transfer one request, optionally record expectation.
  task automatic send(input int t, input int rd, input int rs1, input int rs2,
                      input int f3, input int f7, input int imm, input bit track);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) begin
      check("ready_timeout", 0, 1);
      return;
    end
    type_i = t[1:0]; rd_i = rd[4:0]; rs1_i = rs1[4:0]; rs2_i = rs2[4:0];
    funct3_i = f3[2:0]; funct7_i = f7[6:0]; imm_i = imm; req_valid_i = 1'b1;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    if (track) begin
      if (ref_bad(t, imm)) begin
        exp_q.push_back({1'b1, {ADDR_W{1'b0}}, 32'h0});
        exp_t_q.push_back(cyc);
      end else begin
        exp_q.push_back({1'b0, model_count[ADDR_W-1:0], ref_word(t, rd, rs1, rs2, f3, f7, imm)});
        exp_t_q.push_back(cyc + 1);
        model_count++;
      end
    end
  endtask

  task automatic wait_idle();
    repeat (3) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_i = 1'b1;
    @(posedge clk);
    #1;
    clear_i = 1'b0;
    model_count = 0;
  endtask

  // Monitor: every write or error pulse must match the head of the queue.
  always @(negedge clk) begin
    if (mem_we_o || err_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: we=%0b err=%0b addr=%0h data=%0h expected none",
                 mem_we_o, err_o, mem_addr_o, mem_wdata_o);
      end else begin
        logic [W-1:0] e;
        int           t;
        e = exp_q.pop_front();
        t = exp_t_q.pop_front();
        check("out_cycle", cyc, t);
        if (e[W-1]) begin
          check("err_pulse", {err_o, mem_we_o}, 2'b10);
        end else begin
          check("we_pulse", {err_o, mem_we_o}, 2'b01);
          check("mem_addr", mem_addr_o, e[W-2:32]);
          check("mem_wdata", mem_wdata_o, e[31:0]);
        end
      end
    end
  end

  // Stimulus sequence.
  initial begin
    int t, imm;
    rst_i = 1'b1; req_valid_i = 1'b0; clear_i = 1'b0; type_i = 2'b00;
    rd_i = '0; rs1_i = '0; rs2_i = '0; funct3_i = '0; funct7_i = '0; imm_i = '0;
    repeat (2) @(negedge clk);
    check("rst_outputs", {mem_we_o, err_o, full_o, count_o, mem_addr_o}, 0);
    check("rst_wdata", mem_wdata_o, 0);
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_ready", req_ready_o, 1);

    // Basic R, I, S encodings at addresses 0..2.
    send(0, 3, 1, 2, 0, 0, 0, 1);
    wait_idle();
    check("count_after_r", count_o, model_count);
    send(1, 5, 2, 0, 2, 0, 8, 1);
    send(2, 0, 2, 6, 2, 0, -4, 1);
    wait_idle();
    check("count_after_is", count_o, model_count);

    // Fill to depth, hold a request off, then clear.
    send(0, 7, 8, 9, 5, 32, 0, 1);
    wait_idle();
    check("full_flag", full_o, 1);
    check("full_ready", req_ready_o, 0);
    check("full_count", count_o, DEPTH);
    @(negedge clk);
    req_valid_i = 1'b1;
    repeat (5) @(negedge clk);
    check("full_held_ready", req_ready_o, 0);
    req_valid_i = 1'b0;
    do_clear();
    @(negedge clk);
    check("clear_count", count_o, 0);
    check("clear_ready", {req_ready_o, full_o}, 2'b10);
    send(0, 1, 1, 1, 1, 1, 0, 1);

    // Reserved type and 2048 immediate.
    wait_idle();
    send(3, 4, 4, 4, 4, 4, 0, 1);
    wait_idle();
    check("reserved_count", count_o, model_count);
    send(1, 9, 3, 0, 2, 0, 2048, 1);
    wait_idle();
    check("imm2048_count", count_o, model_count);

    // Async reset while a word is in ENCODE.
    send(0, 2, 2, 2, 0, 0, 0, 0);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    model_count = 0;
    repeat (4) @(negedge clk);
    check("rst_mid_count", count_o, 0);
    check("rst_mid_ready", req_ready_o, 1);

    // clear_i while a word is in ENCODE aborts it.
    send(0, 3, 3, 3, 0, 0, 0, 0);
    clear_i = 1'b1;
    @(posedge clk);
    #1;
    clear_i = 1'b0;
    wait_idle();
    check("clear_mid_count", count_o, 0);

    // Randomized requests.
    for (int i = 0; i < 40; i++) begin
      if (model_count == DEPTH) begin
        wait_idle();
        check("rand_full", {full_o, req_ready_o}, 2'b10);
        do_clear();
      end
      t = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) imm = int'($urandom_range(2048, 100000)) * (($urandom_range(0, 1) == 1) ? -1 : 1);
      else imm = int'($urandom_range(0, 4095)) - 2048;
      send(t, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 127)), imm, 1);
    end
    wait_idle();
    check("rand_count", count_o, model_count);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
